isp_param_loader: RTL and testbench

ISP_PARAM_LOADER -- requirements
Module: isp_param_loader

---
 rtl/isp_param_loader.sv | 119 +++++++++++
 tb/tb_isp_param_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/isp_param_loader.sv
// isp_param_loader: fetches a 4-word ISP parameter table and applies it at the next frame_start (PARAM_LOAD_TIMEOUT_EN adds a mem_ack timeout)
module isp_param_loader #(
  parameter int ADDR_W = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              frame_start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [3:0]        param_sel,
  output logic [31:0]       rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, GAP, WAIT_FS, APPLY, FIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, pbase_q, pbase_d;
  logic [1:0] idx_q, idx_d;
  logic pend_q, pend_d, err_q, err_d;
  logic [31:0] shadow_q [4];
  logic [31:0] shadow_d [4];
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end
`ifdef PARAM_LOAD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic tmo;
  always_comb begin
    cnt_d = (state_q == WAIT_ACK && !mem_ack) ? cnt_q + CW'(1) : '0;
    tmo = state_q == WAIT_ACK && !mem_ack && cnt_q == CW'(TIMEOUT_CYC - 1);
  end
  always_ff @(posedge HCLK)
    cnt_q <= HRESET ? '0 : cnt_d;
`endif
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    pbase_d = pbase_q;
    idx_d = idx_q;
    pend_d = pend_q;
    err_d = 1'b0;
    shadow_d = shadow_q;
    if (start && state_q != IDLE && !pend_q) begin
      pend_d = 1'b1;
      pbase_d = base_addr;
    end
    case (state_q)
      IDLE: if (start) begin
        base_d = base_addr;
        idx_d = '0;
        state_d = REQ;
      end
      REQ, WAIT_ACK: begin
        if (mem_ack) begin
          shadow_d[idx_q] = mem_rdata;
          state_d = GAP;
        end
`ifdef PARAM_LOAD_TIMEOUT_EN
        else if (tmo) begin
          state_d = IDLE;
          err_d = 1'b1;
          pend_d = 1'b0;
        end
`endif
        else state_d = WAIT_ACK;
      end
      GAP: begin
        idx_d = idx_q + 2'd1;
        state_d = idx_q == 2'd3 ? WAIT_FS : REQ;
      end
      WAIT_FS: state_d = frame_start ? APPLY : WAIT_FS;
      APPLY: begin
        idx_d = idx_q + 2'd1;
        state_d = idx_q == 2'd3 ? FIN : APPLY;
      end
      FIN: begin
        state_d = (pend_q || start) ? REQ : IDLE;
        base_d = pend_q ? pbase_q : base_addr;
        idx_d = '0;
        pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge HCLK)
    if (HRESET) begin
      state_q <= IDLE;
      base_q <= '0;
      pbase_q <= '0;
      idx_q <= '0;
      pend_q <= 1'b0;
      err_q <= 1'b0;
      shadow_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      pbase_q <= pbase_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      err_q <= err_d;
      shadow_q <= shadow_d;
    end
  always_comb begin
    mem_req = state_q == REQ || state_q == WAIT_ACK;
    mem_addr = base_q + ADDR_W'(idx_q);
    param_sel = state_q == APPLY ? 4'b1111 >> (2'd3 - idx_q) : 4'b0000;
    rd_data = state_q == APPLY ? shadow_q[idx_q] : 32'd0;
    busy = state_q != IDLE;
    done = state_q == FIN;
    err = err_q;
  end
endmodule

// File: tb/tb_isp_param_loader.sv
// tb_isp_param_loader: scoreboard bench for isp_param_loader with directed loads, pending reload, reset, timeout and wrap cases
module tb_isp_param_loader;
  logic HCLK = 1'b0, HRESET = 1'b1, start = 1'b1, frame_start = 1'b0, mem_ack = 1'b0;
  logic [15:0] base_addr = 16'h0;
  logic [31:0] mem_rdata = 32'h0;
  logic mem_req, busy, done, err;
  logic [15:0] mem_addr;
  logic [3:0] param_sel;
  logic [31:0] rd_data;
  typedef struct {logic [3:0] sel; logic [31:0] data; int cyc;} wr_t;
  wr_t wr_q[$];
  logic [15:0] addr_q[$];
  int done_q[$];
  int checks = 0, errors = 0, cyc = 0, err_exp = 0;
  logic hold_en = 1'b0;
  logic [15:0] hold_addr = 16'h0;
  logic [31:0] mem [logic [15:0]];
  isp_param_loader #(.ADDR_W(16), .TIMEOUT_CYC(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .base_addr(base_addr),
    .frame_start(frame_start), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .param_sel(param_sel),
    .rd_data(rd_data), .busy(busy), .done(done), .err(err)
  );
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : {16'hA5A5, a};
  endfunction
  always @(posedge HCLK)
    if (HRESET) mem_ack <= 1'b0;
    else begin
      mem_ack <= mem_req && !mem_ack && !(hold_en && mem_addr == hold_addr);
      mem_rdata <= mem_word(mem_addr);
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(negedge HCLK) begin
    if (mem_req && mem_ack) begin
      if (addr_q.size() == 0) chk("read_unexpected", {16'h0, mem_addr}, 32'hFFFF_FFFF);
      else chk("read_addr", {16'h0, mem_addr}, {16'h0, addr_q.pop_front()});
    end
    if (param_sel != 4'b0000) begin
      if (wr_q.size() == 0) chk("write_unexpected", {28'h0, param_sel}, 32'h0);
      else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("write_sel", {28'h0, param_sel}, {28'h0, w.sel});
        chk("write_data", rd_data, w.data);
        chk("write_cycle", cyc, w.cyc);
      end
    end
    if (done) begin
      if (done_q.size() == 0) chk("done_unexpected", 32'h1, 32'h0);
      else chk("done_cycle", cyc, done_q.pop_front());
    end
    if (err) begin
      chk("err_expected", err_exp, 32'h1);
      if (err_exp > 0) err_exp--;
    end
  end
  task automatic tick();
    @(negedge HCLK);
    #1;
  endtask
  task automatic do_start(input logic [15:0] a);
    base_addr = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic push_reads(input logic [15:0] a);
    for (int i = 0; i < 4; i++) addr_q.push_back(a + 16'(i));
  endtask
  task automatic wait_reads(input int left);
    int n = 0;
    while (addr_q.size() > left && n < 300) begin
      tick();
      n++;
    end
    chk("reads_left", addr_q.size(), left);
  endtask
  task automatic fs_apply(input logic [31:0] w0, w1, w2, w3);
    int c;
    tick();
    tick();
    frame_start = 1'b1;
    c = cyc;
    wr_q.push_back('{4'b0001, w0, c + 1});
    wr_q.push_back('{4'b0011, w1, c + 2});
    wr_q.push_back('{4'b0111, w2, c + 3});
    wr_q.push_back('{4'b1111, w3, c + 4});
    done_q.push_back(c + 5);
    tick();
    frame_start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while ((wr_q.size() + done_q.size()) > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain", wr_q.size() + done_q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int c;
    mem[16'h0040] = 32'h0000_0005;
    mem[16'h0041] = 32'hF079_0440;
    mem[16'h0042] = 32'h1020_3000;
    mem[16'h0043] = 32'h0000_0002;
    tick();
    tick();
    HRESET = 1'b0;
    start = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_param_sel", param_sel, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done_err", {done, err}, 0);
    repeat (3) tick();
    chk("start_in_reset_discarded", busy, 0);
    do_start(16'h0040);
    push_reads(16'h0040);
    wait_reads(0);
    fs_apply(32'h0000_0005, 32'hF079_0440, 32'h1020_3000, 32'h0000_0002);
    wait_done();
    tick();
    chk("idle_after_done", busy, 0);
    do_start(16'h0500);
    push_reads(16'h0500);
    repeat (4) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_reads(0);
    repeat (20) tick();
    fs_apply(32'hA5A5_0500, 32'hA5A5_0501, 32'hA5A5_0502, 32'hA5A5_0503);
    wait_done();
    do_start(16'h0100);
    push_reads(16'h0100);
    tick();
    tick();
    base_addr = 16'h0200;
    start = 1'b1;
    push_reads(16'h0200);
    tick();
    start = 1'b0;
    tick();
    base_addr = 16'h0300;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_reads(4);
    fs_apply(32'hA5A5_0100, 32'hA5A5_0101, 32'hA5A5_0102, 32'hA5A5_0103);
    wait_reads(0);
    fs_apply(32'hA5A5_0200, 32'hA5A5_0201, 32'hA5A5_0202, 32'hA5A5_0203);
    wait_done();
    repeat (10) tick();
    chk("no_third_reload", busy, 0);
    do_start(16'h0600);
    push_reads(16'h0600);
    wait_reads(0);
    tick();
    tick();
    frame_start = 1'b1;
    c = cyc;
    wr_q.push_back('{4'b0001, 32'hA5A5_0600, c + 1});
    wr_q.push_back('{4'b0011, 32'hA5A5_0601, c + 2});
    tick();
    frame_start = 1'b0;
    tick();
    HRESET = 1'b1;
    tick();
    chk("apply_rst_param_sel", param_sel, 0);
    chk("apply_rst_busy", busy, 0);
    chk("apply_rst_mem_req", mem_req, 0);
    HRESET = 1'b0;
    repeat (10) tick();
    chk("apply_rst_idle", busy, 0);
    chk("apply_rst_no_writes", wr_q.size(), 0);
    do_start(16'hFFFE);
    addr_q.push_back(16'hFFFE);
    addr_q.push_back(16'hFFFF);
    addr_q.push_back(16'h0000);
    addr_q.push_back(16'h0001);
    wait_reads(0);
    fs_apply(32'hA5A5_FFFE, 32'hA5A5_FFFF, 32'hA5A5_0000, 32'hA5A5_0001);
    wait_done();
    hold_en = 1'b1;
    hold_addr = 16'h0802;
    do_start(16'h0800);
    addr_q.push_back(16'h0800);
    addr_q.push_back(16'h0801);
`ifdef PARAM_LOAD_TIMEOUT_EN
    err_exp = 1;
    begin
      int n = 0;
      while (err_exp > 0 && n < 200) begin
        tick();
        n++;
      end
    end
    chk("timeout_err_seen", err_exp, 0);
    chk("timeout_busy", busy, 0);
    chk("timeout_mem_req", mem_req, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (6) tick();
    chk("timeout_param_sel", param_sel, 0);
    chk("timeout_idle", busy, 0);
`else
    repeat (60) tick();
    chk("hang_busy", busy, 1);
    chk("hang_err", err, 0);
    chk("hang_mem_req", mem_req, 1);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
`endif
    hold_en = 1'b0;
    chk("reads_drained", addr_q.size(), 0);
    tick();
    do_start(16'h0700);
    push_reads(16'h0700);
    wait_reads(0);
    fs_apply(32'hA5A5_0700, 32'hA5A5_0701, 32'hA5A5_0702, 32'hA5A5_0703);
    wait_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
